// File: rtl/rx_sampler.sv
// UART receive front end: synchronises rx, oversamples 16x and majority-votes
// each bit, emitting per-bit and per-frame strobes for a downstream shifter.
module rx_sampler #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic rx,
  output logic bit_valid,
  output logic bit_data,
  output logic frame_start,
  output logic frame_done,
  output logic framing_error,
  output logic busy
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (OVERSAMPLE != 16) begin : g_os_bad
      $error("rx_sampler: OVERSAMPLE must be 16");
    end
    if (DIV < 2) begin : g_div_bad
      $error("rx_sampler: CLK_FREQ/(BAUD*16) must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic sync1_q;
  logic rx_s_q;
  logic rx_d_q;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    samp_q, samp_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          s7_q, s7_d;
  logic          s8_q, s8_d;

  logic bit_valid_q, bit_valid_d;
  logic bit_data_q, bit_data_d;
  logic frame_start_q, frame_start_d;
  logic frame_done_q, frame_done_d;
  logic framing_error_q, framing_error_d;

  logic tick;
  logic decide;
  logic wrap;
  logic maj;
  logic fall;

  // Synchroniser and edge-detect flops idle high like the line itself
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  assign tick   = (tick_cnt_q == TW'(DIV - 1));
  assign decide = tick && (samp_q == 4'd9);
  assign wrap   = tick && (samp_q == 4'd15);
  assign maj    = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign fall   = rx_d_q & ~rx_s_q;

  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    samp_d          = samp_q;
    bit_idx_d       = bit_idx_q;
    s7_d            = s7_q;
    s8_d            = s8_q;
    bit_valid_d     = 1'b0;
    bit_data_d      = 1'b0;
    frame_start_d   = 1'b0;
    frame_done_d    = 1'b0;
    framing_error_d = 1'b0;

    if (state_q == IDLE) begin
      tick_cnt_d = '0;
      samp_d     = '0;
      bit_idx_d  = '0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) begin
        samp_d = samp_q + 4'd1;
        if (samp_q == 4'd7) s7_d = rx_s_q;
        if (samp_q == 4'd8) s8_d = rx_s_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (decide) begin
          if (!maj) frame_start_d = 1'b1;
          else      state_d       = IDLE;
        end
        if (wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (decide) begin
          bit_valid_d = 1'b1;
          bit_data_d  = maj;
        end
        if (wrap) begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (decide) begin
          frame_done_d    = 1'b1;
          framing_error_d = ~maj;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      tick_cnt_q      <= '0;
      samp_q          <= '0;
      bit_idx_q       <= '0;
      s7_q            <= 1'b0;
      s8_q            <= 1'b0;
      bit_valid_q     <= 1'b0;
      bit_data_q      <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_done_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      samp_q          <= samp_d;
      bit_idx_q       <= bit_idx_d;
      s7_q            <= s7_d;
      s8_q            <= s8_d;
      bit_valid_q     <= bit_valid_d;
      bit_data_q      <= bit_data_d;
      frame_start_q   <= frame_start_d;
      frame_done_q    <= frame_done_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign bit_valid     = bit_valid_q;
  assign bit_data      = bit_data_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rx_sampler.sv
// Bench for rx_sampler: drives UART frames on rx and checks the strobe
// stream against an event queue built from the frames that were sent.
module tb_rx_sampler;

  localparam int CF  = 1_600_000;
  localparam int BD  = 10_000;
  localparam int BIT = 160;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic bit_valid;
  logic bit_data;
  logic frame_start;
  logic frame_done;
  logic framing_error;
  logic busy;

  always #5 clock = ~clock;

  rx_sampler #(
    .CLK_FREQ(CF),
    .BAUD(BD),
    .OVERSAMPLE(16)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .rx(rx),
    .bit_valid(bit_valid),
    .bit_data(bit_data),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .framing_error(framing_error),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_t = 0;
  int done_t = -1;
  bit bb_chk = 1'b0;
  int exp_q[$];
  int obs;
  int nst;

  // Event codes: 0 start, 2|b data bit, 4|e frame done with error flag e
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      nst = int'(frame_start) + int'(bit_valid) + int'(frame_done);
      if (framing_error) check("ferr_with_done", int'(frame_done), 1);
      if (nst != 0) begin
        check("one_strobe", nst, 1);
        obs = frame_start ? 0 :
              bit_valid   ? (2 + int'(bit_data)) :
                            (4 + int'(framing_error));
        check("event_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("event", obs, exp_q.pop_front());
        if (frame_start) begin
          if (bb_chk && done_t >= 0)
            check("b2b_gap_in_range",
                  int'((cyc - done_t) >= BIT - 10 && (cyc - done_t) <= BIT + 10), 1);
        end else begin
          check("spacing", cyc - last_t, BIT);
        end
        last_t = cyc;
        if (frame_done) done_t = cyc;
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic v, input bit spk);
    rx = v;
    if (spk) begin
      // Inverted for one tick period around sample 8 only
      repeat (85) @(negedge clock);
      rx = ~v;
      repeat (10) @(negedge clock);
      rx = v;
      repeat (65) @(negedge clock);
    end else begin
      repeat (BIT) @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int spk);
    exp_q.push_back(0);
    for (int i = 0; i < 8; i++) exp_q.push_back(2 + int'(d[i]));
    exp_q.push_back(4 + int'(!stop));
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], spk == i);
    send_bit(stop, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_start"}, int'(frame_start), 0);
    check({tag, "_valid"}, int'(bit_valid), 0);
    check({tag, "_data"}, int'(bit_data), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_ferr"}, int'(framing_error), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int cnt;
    bit seen;
    bit fell;
    logic [7:0] d;
    logic stop;
    int spk;
    int gap;

    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check_quiet("reset");
    rst_n = 1'b1;
    idle(20);

    send_frame(8'hA5, 1'b1, -1);
    idle(50);
    check("a5_idle_busy", int'(busy), 0);

    rx = 1'b0;
    cnt = 0;
    seen = 1'b0;
    fell = 1'b0;
    while (cnt < 300 && !fell) begin
      @(negedge clock);
      cnt++;
      if (cnt == 50) rx = 1'b1;
      if (busy) seen = 1'b1;
      else if (seen) fell = 1'b1;
    end
    check("glitch_busy_seen", int'(seen), 1);
    check("glitch_busy_len_ok", int'(fell && cnt >= 95 && cnt <= 110), 1);
    idle(50);

    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b0;
    repeat (400) @(negedge clock);
    check("ferr_low_busy", int'(busy), 0);
    check("ferr_low_drained", exp_q.size(), 0);
    idle(50);

    send_frame(8'h00, 1'b1, -1);
    bb_chk = 1'b1;
    send_frame(8'hFF, 1'b1, -1);
    bb_chk = 1'b0;
    idle(50);

    send_frame(8'h55, 1'b1, 3);
    idle(50);

    d = 8'h96;
    exp_q.push_back(0);
    for (int i = 0; i < 4; i++) exp_q.push_back(2 + int'(d[i]));
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    rx = d[4];
    repeat (80) @(negedge clock);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    check_quiet("abort");
    check("abort_drained", exp_q.size(), 0);
    repeat (17) @(negedge clock);
    rst_n = 1'b1;
    idle(30);
    send_frame(8'h81, 1'b1, -1);
    idle(30);

    for (int f = 0; f < 12; f++) begin
      d = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      spk = int'($urandom_range(9));
      if (spk > 7) spk = -1;
      send_frame(d, stop, spk);
      gap = stop ? int'($urandom_range(200)) : 20 + int'($urandom_range(200));
      idle(gap);
    end

    idle(400);
    check("final_drained", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_sampler.md
RX_SAMPLER -- requirements
Module: rx_sampler

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL provide parameter OVERSAMPLE, default 16, meaning sample ticks per bit (fixed at 16; other values are an elaboration error).
REQ-004 SHALL provide port clock, input, 1 bit: single clock domain, rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL provide port rx, input, 1 bit: raw asynchronous UART RX pin, idle high.
REQ-007 SHALL provide port bit_valid, output, 1 bit: one-cycle strobe, a data bit has been sampled; drives the shift-register enable of the downstream receive datapath.
REQ-008 SHALL provide port bit_data, output, 1 bit: majority-voted data bit, valid when bit_valid=1.
REQ-009 SHALL provide port frame_start, output, 1 bit: one-cycle strobe on a confirmed start bit; used as the downstream shift-register clear.
REQ-010 SHALL provide port frame_done, output, 1 bit: one-cycle strobe at the stop-bit sample point.
REQ-011 SHALL provide port framing_error, output, 1 bit: one-cycle strobe coincident with frame_done when the stop bit samples low.
REQ-012 SHALL provide port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchroniser (rx_s), plus one further flop (rx_d) for edge detection.
REQ-014 SHALL compute DIV = floor(CLK_FREQ/(BAUD*16)), with elaboration error if DIV<2; tick counter counts 0..DIV-1 and asserts tick when count==DIV-1.
REQ-015 SHALL keep a 4-bit sample counter (0..15) incremented on each tick, wrapping 15->0; one wrap = one bit period.
REQ-016 SHALL implement states IDLE, START, DATA, STOP.
REQ-017 IDLE: on rx_d=1 and rx_s=0 (falling edge), go to START and clear the tick and sample counters to 0 in the same cycle; no edge means remain.
REQ-018 SHALL capture rx_s on ticks where the sample counter equals 7, 8, 9, and take the majority of the 3 captures as the bit value, decided on the tick with counter=9.
REQ-019 START: at decision, majority 0 means pulse frame_start and stay until counter wraps, then DATA with bit_idx=0; majority 1 means false start, return to IDLE with no strobe.
REQ-020 DATA: at each decision, pulse bit_valid for 1 cycle with bit_data=majority; on wrap increment bit_idx; after the wrap following bit_idx=7, go to STOP; bits delivered LSB first, exactly 8 per frame.
REQ-021 STOP: at decision, pulse frame_done; pulse framing_error too if majority=0; return to IDLE on the next cycle, not at the bit end, so the next start edge is seen with half-bit margin.
REQ-022 After a framing error (line held low), IDLE SHALL NOT start a new frame until a fresh falling edge, i.e. rx_s must return high first.
REQ-023 At most one of frame_start, bit_valid, frame_done SHALL be high in any cycle.
REQ-024 rx edges while busy SHALL be ignored apart from sampling; there is no mid-frame resync.

Reset
REQ-025 While rst_n=0: state=IDLE, synchroniser and rx_d flops=1, counters=0, bit_idx=0, all outputs 0.
REQ-026 Reset asserted mid-frame SHALL abort immediately with no further strobes; after release, the next falling edge starts a new frame.

Verification (CLK_FREQ=1_600_000, BAUD=10_000 means DIV=10, bit=160 clocks)
REQ-027 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> frame_start once, 8 bit_valid pulses with bit_data 1,0,1,0,0,1,0,1 spaced 160 clocks, first 160 clocks after frame_start; frame_done=1, framing_error=0.
REQ-028 50-clock low glitch on idle line -> no strobes, busy returns to 0 about 100 clocks after the edge.
REQ-029 Frame 0x3C with stop bit low -> 8 bits 0,0,1,1,1,1,0,0, then frame_done=1 and framing_error=1 in the same cycle; no new frame until rx rises then falls.
REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap -> two complete strobe sequences, second frame_start 160 clocks (±10) after the first frame's end.
REQ-031 Single-tick (10-clock) inverted spike inside data bit 3 of 0x55, aligned to sample 8 -> bit_data for bit 3 unchanged (majority).
REQ-032 rst_n pulled low at data bit 4 of a frame, released 20 clocks later, then a frame 0x81 -> no strobes from the aborted frame; 0x81 received correctly.
